// File: rtl/prime_search_ctrl.sv
// Initiator side of the prime-checker handshake: walks a Galois LFSR to form
// odd 32-bit candidates, issues them to the checker and returns the first prime.
module prime_search_ctrl #(
    parameter int unsigned RESULT_LAT   = 3,
    parameter int unsigned MAX_ATTEMPTS = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] seed,
    input  logic        checker_isprime,
    input  logic        checker_done,
    output logic [31:0] checker_candidate,
    output logic        checker_ready,
    output logic [31:0] prime_out,
    output logic        prime_valid,
    output logic        fail,
    output logic        proto_err,
    output logic        busy,
    output logic [15:0] attempts
);

    localparam int unsigned CNT_W     = $clog2(RESULT_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESULT_LAT - 1);
    localparam logic [15:0] MAX_ATT   = 16'(MAX_ATTEMPTS);
    localparam logic [31:0] POLY      = 32'h8020_0003;
    localparam logic [31:0] CAND_MASK = 32'h8000_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RES,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cand_q, cand_d;
    logic             ready_q, ready_d;
    logic [31:0]      prime_q, prime_d;
    logic             pvalid_q, pvalid_d;
    logic             fail_q, fail_d;
    logic             perr_q, perr_d;
    logic             busy_q, busy_d;
    logic [15:0]      att_q, att_d;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    // Next-state and next-output logic; outputs lag the state by one cycle
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        ready_d  = 1'b0;
        prime_d  = prime_q;
        pvalid_d = 1'b0;
        fail_d   = 1'b0;
        perr_d   = perr_q;
        att_d    = att_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_d  = (seed == 32'h0) ? 32'h0000_0001 : seed;
                    att_d   = 16'h0;
                    perr_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cand_d  = lfsr_q | CAND_MASK;
                ready_d = 1'b1;
                if (att_q != MAX_ATT) begin
                    att_d = att_q + 16'd1;
                end
                cnt_d   = CNT_INIT;
                state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                if (!checker_done) begin
                    perr_d  = 1'b1;
                    fail_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (checker_isprime) begin
                    state_d = S_DONE;
                end else if (att_q >= MAX_ATT) begin
                    fail_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lfsr_d  = lfsr_step(lfsr_q);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                prime_d  = cand_q;
                pvalid_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            lfsr_q   <= 32'h0;
            cnt_q    <= '0;
            cand_q   <= 32'h0;
            ready_q  <= 1'b0;
            prime_q  <= 32'h0;
            pvalid_q <= 1'b0;
            fail_q   <= 1'b0;
            perr_q   <= 1'b0;
            busy_q   <= 1'b0;
            att_q    <= 16'h0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            ready_q  <= ready_d;
            prime_q  <= prime_d;
            pvalid_q <= pvalid_d;
            fail_q   <= fail_d;
            perr_q   <= perr_d;
            busy_q   <= busy_d;
            att_q    <= att_d;
        end
    end

    assign checker_candidate = cand_q;
    assign checker_ready     = ready_q;
    assign prime_out         = prime_q;
    assign prime_valid       = pvalid_q;
    assign fail              = fail_q;
    assign proto_err         = perr_q;
    assign busy              = busy_q;
    assign attempts          = att_q;

endmodule

// File: tb/tb_prime_search_ctrl.sv
// Scoreboard bench for prime_search_ctrl: expected candidates and result events
// are queued by the stimulus and popped by a monitor when the DUT presents them.
module tb_prime_search_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] seed;
    logic        checker_isprime;
    logic        checker_done;
    logic [31:0] checker_candidate;
    logic        checker_ready;
    logic [31:0] prime_out;
    logic        prime_valid;
    logic        fail;
    logic        proto_err;
    logic        busy;
    logic [15:0] attempts;

    prime_search_ctrl #(
        .RESULT_LAT  (3),
        .MAX_ATTEMPTS(4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .seed             (seed),
        .checker_isprime  (checker_isprime),
        .checker_done     (checker_done),
        .checker_candidate(checker_candidate),
        .checker_ready    (checker_ready),
        .prime_out        (prime_out),
        .prime_valid      (prime_valid),
        .fail             (fail),
        .proto_err        (proto_err),
        .busy             (busy),
        .attempts         (attempts)
    );

    typedef struct {
        logic [31:0] cand;
        int          cyc;
    } cand_t;

    typedef struct {
        bit          is_fail;
        logic [31:0] data;
        logic [15:0] att;
        bit          perr;
        int          cyc;
    } ev_t;

    cand_t cq[$];
    ev_t   evq[$];
    bit    verd_q[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Checker model: latch the next queued verdict when a request arrives
    always @(negedge clk) begin
        if (reset_n && checker_ready) begin
            checker_isprime = (verd_q.size() != 0) ? verd_q.pop_front() : 1'b0;
        end
    end

    // Monitor: pop and compare whenever the DUT presents a request or a result
    always @(negedge clk) begin
        cand_t c;
        ev_t   e;
        if (reset_n) begin
            if (checker_ready) begin
                if (cq.size() == 0) begin
                    chk("unexpected_ready", 32'(checker_ready), 32'h0);
                end else begin
                    c = cq.pop_front();
                    chk("candidate", checker_candidate, c.cand);
                    chk("ready_cycle", 32'(cyc), 32'(c.cyc));
                end
            end
            if (prime_valid && fail) chk("valid_and_fail", 32'(fail), 32'h0);
            if (prime_valid || fail) begin
                if (evq.size() == 0) begin
                    chk("unexpected_result", 32'(prime_valid | fail), 32'h0);
                end else begin
                    e = evq.pop_front();
                    chk("result_kind_fail", 32'(fail), 32'(e.is_fail));
                    if (!e.is_fail) chk("prime_out", prime_out, e.data);
                    chk("attempts", 32'(attempts), 32'(e.att));
                    chk("proto_err", 32'(proto_err), 32'(e.perr));
                    chk("result_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_at_result", 32'(busy), 32'h0);
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] s, output int k);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((cq.size() != 0 || evq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("drain_timeout", 32'(cq.size() + evq.size()), 32'h0);
            cq.delete();
            evq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_candidate"}, checker_candidate, 32'h0);
        chk({tag, "_ready"}, 32'(checker_ready), 32'h0);
        chk({tag, "_prime_out"}, prime_out, 32'h0);
        chk({tag, "_prime_valid"}, 32'(prime_valid), 32'h0);
        chk({tag, "_fail"}, 32'(fail), 32'h0);
        chk({tag, "_proto_err"}, 32'(proto_err), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_attempts"}, 32'(attempts), 32'h0);
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        start = 1'b0;
        seed = 32'h0;
        checker_done = 1'b1;
        checker_isprime = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset asserted while waiting for the verdict abandons the search
        verd_q.push_back(1'b1);
        do_start(32'h1, k);
        cq.push_back('{32'h8000_0001, k + 1});
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'h0);
        chk("post_reset_ready", 32'(checker_ready), 32'h0);
        verd_q.delete();

        // First-try prime
        verd_q.push_back(1'b1);
        do_start(32'h1, k);
        cq.push_back('{32'h8000_0001, k + 1});
        evq.push_back('{1'b0, 32'h8000_0001, 16'd1, 1'b0, k + 6});
        wait_drain();

        // One retry
        verd_q.push_back(1'b0);
        verd_q.push_back(1'b1);
        do_start(32'h1, k);
        cq.push_back('{32'h8000_0001, k + 1});
        cq.push_back('{32'h8020_0003, k + 6});
        evq.push_back('{1'b0, 32'h8020_0003, 16'd2, 1'b0, k + 11});
        wait_drain();

        // Budget exhaustion with MAX_ATTEMPTS=4
        repeat (4) verd_q.push_back(1'b0);
        do_start(32'h1, k);
        cq.push_back('{32'h8000_0001, k + 1});
        cq.push_back('{32'h8020_0003, k + 6});
        cq.push_back('{32'hC030_0003, k + 11});
        cq.push_back('{32'hE018_0001, k + 16});
        evq.push_back('{1'b1, 32'h0, 16'd4, 1'b0, k + 20});
        wait_drain();
        chk("exhaust_prime_held", prime_out, 32'h8020_0003);
        chk("exhaust_attempts_held", 32'(attempts), 32'd4);

        // Protocol error: done low at the sample point
        checker_done = 1'b0;
        verd_q.push_back(1'b1);
        do_start(32'h1, k);
        cq.push_back('{32'h8000_0001, k + 1});
        evq.push_back('{1'b1, 32'h0, 16'd1, 1'b1, k + 5});
        wait_drain();
        chk("proto_err_sticky", 32'(proto_err), 32'h1);
        checker_done = 1'b1;

        // Zero seed, plus a start while busy that must be ignored
        verd_q.push_back(1'b0);
        verd_q.push_back(1'b1);
        do_start(32'h0, k);
        chk("proto_err_cleared", 32'(proto_err), 32'h0);
        cq.push_back('{32'h8000_0001, k + 1});
        cq.push_back('{32'h8020_0003, k + 6});
        evq.push_back('{1'b0, 32'h8020_0003, 16'd2, 1'b0, k + 11});
        @(negedge clk);
        seed  = 32'h1234_5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        chk("final_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prime_search_ctrl.md
Name: prime_search_ctrl

Overview:
- Initiator side of the prime-checker ready/done handshake for the RSA key path.
- Accepts a 32-bit seed on start and forms large odd candidates from a Galois LFSR.
- Issues each candidate to the prime checker and samples its verdict, retrying until a prime is found or the attempt budget runs out.
- Returns the prime to key generation with a one-cycle valid pulse.

Parameters:
- RESULT_LAT, 3: cycles between the checker_ready pulse and the result sample point (must be >= 2).
- MAX_ATTEMPTS, 1000: candidates tried before giving up (1..65535).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a search; sampled only in IDLE.
- seed  in  32  LFSR seed, captured on an accepted start.
- checker_isprime  in  1  prime verdict from the checker.
- checker_done  in  1  checker completion flag (may stay high between runs).
- checker_candidate  out  32  candidate driven to the checker.
- checker_ready  out  1  one-cycle request pulse to the checker.
- prime_out  out  32  last prime found; held until the next success.
- prime_valid  out  1  one-cycle pulse: prime_out updated.
- fail  out  1  one-cycle pulse: budget exhausted or protocol error.
- proto_err  out  1  sticky: checker_done was low at a sample point; cleared on an accepted start.
- busy  out  1  high in every state except IDLE.
- attempts  out  16  candidates issued in the current or last search.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, lfsr=0, wait counter=0.
  - A reset mid-search abandons the search.
  - checker_ready drops immediately.
- All outputs are registered.
- LFSR step: next = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0).
- Candidate = s | 32'h80000001, so bit 31 and bit 0 are always set.
- A seed of 0 is replaced by 32'h00000001 on capture.
- States: IDLE, ISSUE, WAIT_RES, SAMPLE, DONE.
- IDLE:
  - On start=1: capture seed into lfsr, attempts=0, clear proto_err, go to ISSUE.
  - start is ignored in every other state.
- ISSUE (1 cycle):
  - checker_candidate = candidate(lfsr), checker_ready=1, attempts+=1.
  - Go to WAIT_RES with counter=RESULT_LAT-1.
- WAIT_RES:
  - checker_ready=0; checker_candidate stays held.
  - Decrement counter; go to SAMPLE when the counter is 0.
  - Occupies RESULT_LAT cycles in total.
- SAMPLE (1 cycle): evaluate in this order:
  - checker_done=0: set proto_err, pulse fail next cycle, go to IDLE.
  - checker_isprime=1: go to DONE.
  - attempts==MAX_ATTEMPTS: pulse fail, go to IDLE.
  - Otherwise: advance lfsr one step, go to ISSUE.
- DONE (1 cycle): prime_out = checker_candidate, prime_valid=1, then go to IDLE.
- Latency:
  - start sampled at edge k: checker_ready is high in cycle k+1.
  - First-try prime: prime_valid is high in cycle k+RESULT_LAT+3.
  - Each retry adds RESULT_LAT+2 cycles.
- attempts saturates at MAX_ATTEMPTS and never wraps.
- prime_valid and fail are never high in the same cycle.
- busy is low for the cycle in which the prime_valid or fail pulse is visible, so a new start is accepted that same cycle.

Test Plan:
- Reset: reset_n=0 mid-WAIT_RES -> all outputs 0 immediately; after release, busy=0 and checker_ready stays 0 with start=0.
- First-try prime, RESULT_LAT=3, seed=1, model returns isprime=1 and done=1:
  - checker_candidate=32'h80000001 and checker_ready high in cycle 1.
  - prime_valid in cycle 6, prime_out=32'h80000001, attempts=1.
- Retry, seed=1, model answers 0 then 1:
  - second checker_candidate=32'h80200003.
  - prime_valid in cycle 11, attempts=2.
- Budget exhaustion, MAX_ATTEMPTS=4, model always returns 0:
  - four checker_ready pulses, then a single fail pulse.
  - attempts=4, prime_valid never asserts, prime_out unchanged.
- Protocol error, model holds done=0 -> proto_err=1, fail pulse after the first sample; the next start clears proto_err.
- seed=0 -> first checker_candidate=32'h80000001; start pulsed while busy -> ignored, seed not recaptured.
